hs_ram_arbiter: RTL
===================

# hs_ram_arbiter

Shares the game's work-RAM port between the main CPU and the hiscore save/restore engine. Sits between `performan_fpga` work RAM and the `hiscore` block. Hands the port to the hiscore side only while the pause system holds the CPU halted and after in-flight CPU cycles have drained. Address-window checking keeps hiscore traffic inside the configured RAM range.

## Interface
Parameters:
- `ADDR_W`, 16, address width on all three sides.
- `DATA_W`, 8, data width.
- `WIN_LO`, 16'h0000, lowest RAM address the hiscore side may touch.
- `WIN_HI`, 16'hFFFF, highest RAM address the hiscore side may touch.
- `DRAIN_CYC`, 4, clk_sys cycles waited after pause before granting (range 1..15).

Ports:
- `clk_sys`  in  1  system clock. One clock only.
- `RESET_n`  in  1  reset; asynchronous assert, active-low.
- `pause_cpu`  in  1  CPU halted, from the pause system.
- `cpu_cs`  in  1  CPU RAM select.
- `cpu_we`  in  1  CPU write strobe, qualified by `cpu_cs`.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_din`  in  DATA_W  CPU write data.
- `cpu_dout`  out  DATA_W  CPU read data.
- `cpu_wait`  out  1  CPU access blocked.
- `hs_address`  in  ADDR_W  hiscore address.
- `hs_data_in`  in  DATA_W  hiscore write data.
- `hs_write`  in  1  hiscore write strobe.
- `hs_access_read`  in  1  hiscore read intent.
- `hs_access_write`  in  1  hiscore write intent.
- `hs_data_out`  out  DATA_W  hiscore read data.
- `hs_grant`  out  1  hiscore owns the port.
- `hs_oob`  out  1  pulse: hiscore access outside the address window.
- `hs_abort`  out  1  pulse: grant revoked because pause dropped.
- `ram_addr`  out  ADDR_W  RAM address (registered).
- `ram_din`  out  DATA_W  RAM write data (registered).
- `ram_we`  out  1  RAM write enable (registered).
- `ram_dout`  in  DATA_W  RAM read data; synchronous, 1-cycle latency.

## Operation
- States:
  - S_CPU: the CPU owns the port. Reset state.
  - S_DRAIN: wait before granting.
  - S_HS: the hiscore side owns the port.
  - S_TURN: one-cycle turnaround with `ram_we` forced to 0.
- Intent is `hs_access_read | hs_access_write`.
- S_CPU → S_DRAIN when intent and `pause_cpu` are both high.
- S_DRAIN:
  - A 4-bit counter loads `DRAIN_CYC-1` on entry and decrements each cycle.
  - If intent or `pause_cpu` drops, go back to S_CPU; no pulse.
  - When the counter reaches 0, go to S_HS.
- S_HS:
  - `hs_grant`=1.
  - If intent drops, go to S_TURN.
  - If `pause_cpu` drops, go to S_TURN and pulse `hs_abort` for 1 cycle. This check has priority when both drop in the same cycle.
- S_TURN → S_CPU unconditionally.
- Mux selection:
  - S_CPU: the CPU drives `ram_addr`/`ram_din`, and `ram_we` = `cpu_cs & cpu_we`.
  - S_HS: the hiscore side drives the port, and `ram_we` = `hs_write & in_window`.
  - S_DRAIN and S_TURN: `ram_we`=0 and `ram_addr` holds its value.
- Window: `in_window` = `WIN_LO <= hs_address <= WIN_HI`, unsigned, inclusive.
  - In S_HS with an access outside the window, `hs_oob` pulses that cycle and the write is suppressed.
  - The returned read data is 0.
- `cpu_wait` = `cpu_cs & (state != S_CPU)`. A CPU access outside S_CPU is never forwarded to RAM.
- Read capture:
  - `cpu_dout` loads `ram_dout` only for data from a CPU-owned address cycle; otherwise it holds.
  - `hs_data_out` loads `ram_dout` (or 0 if out of window) only for data from an S_HS cycle.
- Reset: all outputs 0 and state S_CPU. An asynchronous assert mid-grant drops `hs_grant` immediately. No RAM write is issued after reset is asserted.

## Timing
- RAM port outputs are registered: address/data/we become visible 1 cycle after the source inputs.
- Read latency from source address to `cpu_dout`/`hs_data_out` is 2 cycles (1 register + 1 RAM cycle).
- Grant latency: intent and pause both high at cycle N → `hs_grant` high at N+1+`DRAIN_CYC`.
- Release: intent low at cycle M → `hs_grant` low at M+1; the CPU owns the port again at M+2.
- `hs_abort` and `hs_oob` are single-cycle, registered pulses.
- Back-to-back hiscore accesses in S_HS run at one per cycle with no bubbles.
- A CPU access still pending in S_CPU at the transition cycle completes. Its read capture is honoured through the `ram_dout` latency, even though the state has already advanced.

## Structure
- Shared package `hs_arb_pkg`: state enum `hs_arb_state_t` (S_CPU, S_DRAIN, S_HS, S_TURN) and the default `WIN_LO`/`WIN_HI`/`DRAIN_CYC` constants.
- Single module with no sub-modules. The drain counter and the owner-tag pipeline register (which tracks who owns the in-flight read) are inline.

## Test plan
- `DRAIN_CYC`=4; raise `hs_access_write` and `pause_cpu` at cycle 10 → `hs_grant` at 15; `hs_write` to 16'h0120 with data 8'hA5 → `ram_we`=1 at 16, `ram_din`=8'hA5.
- `WIN_LO`=16'h0100, `WIN_HI`=16'h01FF; hiscore write to 16'h0200 → `ram_we` stays 0, `hs_oob` pulses once; hiscore read there → `hs_data_out`=8'h00.
- Drop `pause_cpu` while in S_HS → `hs_abort` pulses 1 cycle, `hs_grant` is 0 the next cycle, the CPU owns the port 2 cycles later.
- CPU read from 16'h0150 while idle → `cpu_dout` equals the RAM content 2 cycles later; `cpu_cs` asserted during S_HS → `cpu_wait`=1 and `ram_we`=0.
- Intent drops during S_DRAIN → return to S_CPU, `hs_grant` never asserts, no pulses.
- Assert `RESET_n`=0 mid-grant → all outputs 0 immediately; after release, state is S_CPU.

Source files
------------

// File: rtl/hs_arb_pkg.sv
// Shared types and default constants for the hiscore/CPU work-RAM arbiter.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    S_CPU   = 2'd0,
    S_DRAIN = 2'd1,
    S_HS    = 2'd2,
    S_TURN  = 2'd3
  } hs_arb_state_t;

  localparam logic [15:0] WIN_LO_DEF    = 16'h0000;
  localparam logic [15:0] WIN_HI_DEF    = 16'hFFFF;
  localparam int unsigned DRAIN_CYC_DEF = 4;

endpackage

// File: rtl/hs_ram_arbiter.sv
// Shares the work-RAM port between the main CPU and the hiscore engine; the
// hiscore side is granted only while the CPU is paused and after a drain delay.
module hs_ram_arbiter
  import hs_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 16,
  parameter int unsigned       DATA_W    = 8,
  parameter logic [ADDR_W-1:0] WIN_LO    = ADDR_W'(WIN_LO_DEF),
  parameter logic [ADDR_W-1:0] WIN_HI    = ADDR_W'(WIN_HI_DEF),
  parameter int unsigned       DRAIN_CYC = DRAIN_CYC_DEF
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              pause_cpu,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_wait,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write,
  input  logic              hs_access_read,
  input  logic              hs_access_write,
  output logic [DATA_W-1:0] hs_data_out,
  output logic              hs_grant,
  output logic              hs_oob,
  output logic              hs_abort,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYC - 1);

  hs_arb_state_t state, state_d;
  logic [3:0]    drain_cnt;
  logic          intent;
  logic          in_window;
  logic          abort_d;
  logic [ADDR_W:0] win_off;

  // Owner tags follow each read address through the register and RAM stages.
  logic cpu_rd1, cpu_rd2;
  logic hs_rd1, hs_rd2;
  logic oob1, oob2;
  logic [DATA_W-1:0] cpu_hold, hs_hold;

  assign intent = hs_access_read | hs_access_write;

  // Offset from WIN_LO with a spare bit: addresses below WIN_LO wrap above any span.
  assign win_off   = {1'b0, hs_address} - {1'b0, WIN_LO};
  assign in_window = (win_off <= {1'b0, WIN_HI - WIN_LO});

  assign hs_grant = (state == S_HS);
  assign cpu_wait = cpu_cs & (state != S_CPU);

  always_comb begin
    state_d = state;
    abort_d = 1'b0;
    case (state)
      S_CPU: begin
        if (intent && pause_cpu) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!intent || !pause_cpu) state_d = S_CPU;
        else if (drain_cnt == 4'd0) state_d = S_HS;
      end
      S_HS: begin
        if (!pause_cpu) begin
          state_d = S_TURN;
          abort_d = 1'b1;
        end else if (!intent) begin
          state_d = S_TURN;
        end
      end
      S_TURN:  state_d = S_CPU;
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state     <= S_CPU;
      drain_cnt <= '0;
    end else begin
      state <= state_d;
      if (state == S_CPU)
        drain_cnt <= DRAIN_LOAD;
      else if (state == S_DRAIN && drain_cnt != 4'd0)
        drain_cnt <= drain_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      ram_addr <= '0;
      ram_din  <= '0;
      ram_we   <= 1'b0;
      hs_oob   <= 1'b0;
      hs_abort <= 1'b0;
      cpu_rd1  <= 1'b0;
      cpu_rd2  <= 1'b0;
      hs_rd1   <= 1'b0;
      hs_rd2   <= 1'b0;
      oob1     <= 1'b0;
      oob2     <= 1'b0;
      cpu_hold <= '0;
      hs_hold  <= '0;
    end else begin
      hs_abort <= abort_d;
      hs_oob   <= (state == S_HS) && (hs_write || hs_access_read) && !in_window;
      case (state)
        S_CPU: begin
          ram_addr <= cpu_addr;
          ram_din  <= cpu_din;
          ram_we   <= cpu_cs & cpu_we;
        end
        S_HS: begin
          ram_addr <= hs_address;
          ram_din  <= hs_data_in;
          ram_we   <= hs_write & in_window;
        end
        default: ram_we <= 1'b0;
      endcase
      cpu_rd1  <= (state == S_CPU) && cpu_cs && !cpu_we;
      hs_rd1   <= (state == S_HS) && hs_access_read && !hs_write;
      oob1     <= !in_window;
      cpu_rd2  <= cpu_rd1;
      hs_rd2   <= hs_rd1;
      oob2     <= oob1;
      cpu_hold <= cpu_dout;
      hs_hold  <= hs_data_out;
    end
  end

  // Read data passes straight from the RAM in its tagged cycle, then holds.
  assign cpu_dout    = cpu_rd2 ? ram_dout : cpu_hold;
  assign hs_data_out = hs_rd2 ? (oob2 ? '0 : ram_dout) : hs_hold;

endmodule
